// File: rtl/lpcm_dut_if.sv
`default_nettype none
// ============================================================================
//  Module      : lpcm_dut_if
//  Description : LPCM sample stream bundle. The source drives the input
//                strobe/sample pair; the pipeline drives the output pair.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lpcm_dut_if;
  logic        enIn;
  logic [31:0] dataIn;
  logic        enOut;
  logic [31:0] dataOut;

  // Source / sink side of the stream (testbench or upstream block)
  modport master (
    output enIn,
    output dataIn,
    input  enOut,
    input  dataOut
  );

  // Pipeline side of the stream
  modport slave (
    input  enIn,
    input  dataIn,
    output enOut,
    output dataOut
  );
endinterface
`default_nettype wire

// File: rtl/lpcm_dut.sv
`default_nettype none
// ============================================================================
//  Module      : lpcm_dut
//  Description : Fixed-latency LPCM sample pipeline. Every accepted sample is
//                re-emitted LATENCY cycles later with bits below SAMPLE_BITS
//                cleared. Data words of empty stages are held at zero so the
//                output bus is quiet whenever the output strobe is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module lpcm_dut #(
  parameter int LATENCY     = 2,   // 1..16
  parameter int SAMPLE_BITS = 32   // 1..32
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  lpcm_dut_if.slave   lpcm
);

  // Left-justified samples: keep the SAMPLE_BITS most significant bits.
  localparam logic [31:0] C_KEEP_MASK = 32'hFFFF_FFFF << (32 - SAMPLE_BITS);

  logic                      w_en0;
  logic [31:0]               w_dat0;
  logic [LATENCY-1:0]        r_vld;
  logic [LATENCY-1:0][31:0]  r_dat;

  // Stage-0 load value: the strobe gates the data, so an idle or undefined
  // dataIn never enters the pipeline.
  always_comb begin
    w_en0  = lpcm.enIn;
    w_dat0 = '0;
    if (lpcm.enIn) begin
      w_dat0 = lpcm.dataIn & C_KEEP_MASK;
    end
  end

  // Shift pipeline: stage 0 takes the new sample, stage k takes stage k-1;
  // reset clears every stage immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_dat <= '0;
    end else begin
      r_vld[0] <= w_en0;
      r_dat[0] <= w_dat0;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_dat[k] <= r_dat[k-1];
      end
    end
  end

  assign lpcm.enOut   = r_vld[LATENCY-1];
  assign lpcm.dataOut = r_dat[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_lpcm_dut.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lpcm_dut
//  Description : Directed bench for lpcm_dut. Two instances share stimulus:
//                u_dut0 with default parameters (LATENCY 2, 32 bits) and
//                u_dut1 with LATENCY 3 and SAMPLE_BITS 16.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lpcm_dut;

  localparam int          C_LAT0  = 2;
  localparam int          C_LAT1  = 3;
  localparam logic [31:0] C_MASK1 = 32'hFFFF_0000;

  logic clk;
  logic rst_n;

  lpcm_dut_if if0 ();
  lpcm_dut_if if1 ();

  lpcm_dut u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .lpcm  (if0)
  );

  lpcm_dut #(.LATENCY(C_LAT1), .SAMPLE_BITS(16)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .lpcm  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic        v_en  [128];
  logic [31:0] v_dat [128];

  // Single comparison point: count it, report on mismatch.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [31:0] d);
    if0.enIn   = en;
    if0.dataIn = d;
    if1.enIn   = en;
    if1.dataIn = d;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_en0"},  {31'd0, if0.enOut}, 32'd0);
    chk({tag, "_dat0"}, if0.dataOut,        32'd0);
    chk({tag, "_en1"},  {31'd0, if1.enOut}, 32'd0);
    chk({tag, "_dat1"}, if1.dataOut,        32'd0);
  endtask

  // Plays v_en/v_dat[0..n-1] starting at a negedge with empty pipelines,
  // then idles with X data; checks both outputs every cycle. A sample driven
  // at negedge k must be visible at negedge k+LATENCY.
  task automatic run(input string tag, input int n);
    logic [31:0] e_en0, e_dat0, e_en1, e_dat1;
    for (int k = 0; k <= n + C_LAT1; k++) begin
      e_en0 = 32'd0; e_dat0 = 32'd0;
      e_en1 = 32'd0; e_dat1 = 32'd0;
      if (k >= C_LAT0 && k - C_LAT0 < n && v_en[k-C_LAT0]) begin
        e_en0  = 32'd1;
        e_dat0 = v_dat[k-C_LAT0];
      end
      if (k >= C_LAT1 && k - C_LAT1 < n && v_en[k-C_LAT1]) begin
        e_en1  = 32'd1;
        e_dat1 = v_dat[k-C_LAT1] & C_MASK1;
      end
      chk({tag, "_en0"},  {31'd0, if0.enOut}, e_en0);
      chk({tag, "_dat0"}, if0.dataOut,        e_dat0);
      chk({tag, "_en1"},  {31'd0, if1.enOut}, e_en1);
      chk({tag, "_dat1"}, if1.dataOut,        e_dat1);
      if (k < n && v_en[k]) drive(1'b1, v_dat[k]);
      else                  drive(1'b0, 32'hxxxx_xxxx);
      @(negedge clk);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b1, 32'hDEAD_BE00);

    // Held in reset with an active strobe: outputs stay zero.
    repeat (5) begin
      @(negedge clk);
      chk_quiet("rst_hold");
    end

    // First post-reset sample emerges exactly LATENCY edges later.
    rst_n = 1'b1;
    v_en[0] = 1'b1; v_dat[0] = 32'hDEAD_BE00;
    run("rst_first", 1);

    // Single sample.
    v_en[0] = 1'b1; v_dat[0] = 32'h8000_0001;
    run("single", 1);

    // Back-to-back burst of 100 samples.
    for (int i = 0; i < 100; i++) begin
      v_en[i]  = 1'b1;
      v_dat[i] = 32'h0000_0100 * i;
    end
    run("burst", 100);

    // Gapped stream 1,0,0,1,1,0,1 with incrementing data.
    v_en[0] = 1'b1; v_dat[0] = 32'h0101_0101;
    v_en[1] = 1'b0; v_dat[1] = 32'h0;
    v_en[2] = 1'b0; v_dat[2] = 32'h0;
    v_en[3] = 1'b1; v_dat[3] = 32'h0202_0202;
    v_en[4] = 1'b1; v_dat[4] = 32'h0303_0303;
    v_en[5] = 1'b0; v_dat[5] = 32'h0;
    v_en[6] = 1'b1; v_dat[6] = 32'h0404_0404;
    run("gap", 7);

    // Width masking (u_dut1 keeps 16 MSBs).
    v_en[0] = 1'b1; v_dat[0] = 32'h1234_5678;
    v_en[1] = 1'b1; v_dat[1] = 32'hABCD_0000;
    v_en[2] = 1'b1; v_dat[2] = 32'h8000_0000;
    v_en[3] = 1'b1; v_dat[3] = 32'hFFFF_0001;
    run("mask", 4);
    chk("mask_const", 32'h1234_5678 & C_MASK1, 32'h1234_0000);

    // Mid-stream reset with samples in flight.
    drive(1'b1, 32'hAAAA_0001);
    @(negedge clk);
    drive(1'b1, 32'hBBBB_0002);
    @(negedge clk);
    drive(1'b1, 32'hCCCC_0003);
    #1;
    chk("midrst_pre_en0",  {31'd0, if0.enOut}, 32'd1);
    chk("midrst_pre_dat0", if0.dataOut,        32'hAAAA_0001);
    rst_n = 1'b0;
    drive(1'b0, 32'hxxxx_xxxx);
    #1;
    chk_quiet("midrst_async");
    @(negedge clk);
    chk_quiet("midrst_held");
    rst_n = 1'b1;

    // Fresh samples after reset; none of the discarded ones may appear.
    v_en[0] = 1'b1; v_dat[0] = 32'h1111_0000;
    v_en[1] = 1'b1; v_dat[1] = 32'h2222_0000;
    v_en[2] = 1'b1; v_dat[2] = 32'h3333_0000;
    run("post_rst", 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
